// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// cpu_ctrl_pkg : states, opcodes, IR field positions and opcode classification
//                shared by the mini-CPU control sequencer.
// Revision     : 1.0
// ============================================================================
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    localparam logic [4:0] c_OP_ADD  = 5'd3;
    localparam logic [4:0] c_OP_SUB  = 5'd4;
    localparam logic [4:0] c_OP_AND  = 5'd5;
    localparam logic [4:0] c_OP_OR   = 5'd6;
    localparam logic [4:0] c_OP_SHR  = 5'd7;
    localparam logic [4:0] c_OP_SHL  = 5'd8;
    localparam logic [4:0] c_OP_ROR  = 5'd9;
    localparam logic [4:0] c_OP_ROL  = 5'd10;
    localparam logic [4:0] c_OP_ADDI = 5'd12;
    localparam logic [4:0] c_OP_ANDI = 5'd13;
    localparam logic [4:0] c_OP_ORI  = 5'd14;
    localparam logic [4:0] c_OP_MUL  = 5'd15;
    localparam logic [4:0] c_OP_DIV  = 5'd16;
    localparam logic [4:0] c_OP_NOP  = 5'd26;
    localparam logic [4:0] c_OP_HALT = 5'd27;

    localparam int c_IR_OP_LSB = 27;
    localparam int c_IR_RA_LSB = 23;
    localparam int c_IR_RB_LSB = 19;
    localparam int c_IR_RC_LSB = 15;

    function automatic logic is_reg_op(input logic [4:0] op);
        return (op >= c_OP_ADD) && (op <= c_OP_ROL);
    endfunction

    function automatic logic is_imm_op(input logic [4:0] op);
        return (op >= c_OP_ADDI) && (op <= c_OP_ORI);
    endfunction

    function automatic logic is_muldiv_op(input logic [4:0] op);
        return (op == c_OP_MUL) || (op == c_OP_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_decoder.sv
`default_nettype none
// ============================================================================
// onehot_decoder : binary index plus enable to one-hot vector (zero if disabled)
// Revision       : 1.0
// ============================================================================
module onehot_decoder #(
    parameter int IDX_W = 4,
    parameter int COUNT = 16
) (
    input  logic [IDX_W-1:0] i_idx,
    input  logic             i_en,
    output logic [COUNT-1:0] o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_idx] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// control_sequencer : Moore control-step FSM (fetch T0-T2, execute T3-T6) for
//                     the mini CPU; CTRL_MULDIV_EN enables mul/div execution.
// Revision          : 1.0
// ============================================================================
module control_sequencer #(
    parameter int REG_COUNT   = 16,
    parameter int REG_IDX_W   = 4,
    parameter int OPCODE_W    = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                 Clock,
    input  logic                 clear,
    input  logic                 run,
    input  logic                 mem_ready,
    input  logic [31:0]          IR,
    output logic                 PCout,
    output logic                 Zhighout,
    output logic                 Zlowout,
    output logic                 MDRout,
    output logic                 Cout,
    output logic                 MARin,
    output logic                 Zin,
    output logic                 PCin,
    output logic                 MDRin,
    output logic                 IRin,
    output logic                 Yin,
    output logic                 HIin,
    output logic                 LOin,
    output logic                 IncPC,
    output logic                 Read,
    output logic [REG_COUNT-1:0] Rout,
    output logic [REG_COUNT-1:0] Rin,
    output logic [OPCODE_W-1:0]  alu_op,
    output logic                 busy,
    output logic                 halted,
    output logic                 illegal,
    output logic                 mem_fault
);
    import cpu_ctrl_pkg::*;

`ifdef CTRL_MULDIV_EN
    localparam logic c_MULDIV_EN = 1'b1;
`else
    localparam logic c_MULDIV_EN = 1'b0;
`endif

    localparam int                c_WAIT_W  = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_TIMEOUT = c_WAIT_W'(MEM_TIMEOUT);

    state_t                r_state, w_next;
    logic [OPCODE_W-1:0]   r_opcode;
    logic [REG_IDX_W-1:0]  r_ra, r_rb, r_rc;
    logic [c_WAIT_W-1:0]   r_wait;
    logic                  r_halted, r_illegal, r_fault;

    logic w_is_reg, w_is_imm, w_is_md, w_is_alu, w_exec, w_is_nop, w_is_halt, w_legal;
    logic w_timeout, w_end_state;
    logic w_rout_en, w_rin_en;
    logic [REG_IDX_W-1:0] w_rout_idx;
    logic w_unused;

    assign w_is_reg    = is_reg_op(r_opcode);
    assign w_is_imm    = is_imm_op(r_opcode);
    assign w_is_md     = c_MULDIV_EN && is_muldiv_op(r_opcode);
    assign w_is_alu    = w_is_reg || w_is_imm;
    assign w_exec      = w_is_alu || w_is_md;
    assign w_is_nop    = (r_opcode == c_OP_NOP);
    assign w_is_halt   = (r_opcode == c_OP_HALT);
    assign w_legal     = w_exec || w_is_nop || w_is_halt;
    assign w_timeout   = (r_wait == c_TIMEOUT);
    assign w_end_state = run ? S_T0 : S_IDLE;
    assign w_unused    = ^IR;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (run) w_next = S_T0;
            S_T0:   w_next = S_T1;
            S_T1: begin
                // A ready arriving on the timeout cycle still wins.
                if (mem_ready)      w_next = S_T2;
                else if (w_timeout) w_next = S_HALT;
            end
            S_T2:   w_next = S_T3;
            S_T3: begin
                if (w_is_halt)   w_next = S_HALT;
                else if (w_exec) w_next = S_T4;
                else             w_next = state_t'(w_end_state);
            end
            S_T4:   w_next = S_T5;
            S_T5:   w_next = w_is_md ? S_T6 : state_t'(w_end_state);
            S_T6:   w_next = state_t'(w_end_state);
            S_HALT: w_next = S_HALT;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            r_state   <= S_IDLE;
            r_opcode  <= '0;
            r_ra      <= '0;
            r_rb      <= '0;
            r_rc      <= '0;
            r_wait    <= '0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_T2) begin
                r_opcode <= IR[c_IR_OP_LSB +: OPCODE_W];
                r_ra     <= IR[c_IR_RA_LSB +: REG_IDX_W];
                r_rb     <= IR[c_IR_RB_LSB +: REG_IDX_W];
                r_rc     <= IR[c_IR_RC_LSB +: REG_IDX_W];
            end
            if (r_state == S_T1 && !mem_ready && !w_timeout) r_wait <= r_wait + 1'b1;
            else                                             r_wait <= '0;
            if (w_next == S_HALT) r_halted <= 1'b1;
            if (r_state == S_T1 && !mem_ready && w_timeout) r_fault <= 1'b1;
            if (r_state == S_T3 && !w_legal) r_illegal <= 1'b1;
        end
    end

    always_comb begin
        PCout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; Cout = 1'b0;
        MARin = 1'b0; Zin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0;
        Yin = 1'b0; HIin = 1'b0; LOin = 1'b0; IncPC = 1'b0; Read = 1'b0;
        alu_op     = '0;
        w_rout_en  = 1'b0;
        w_rout_idx = r_rc;
        w_rin_en   = 1'b0;
        case (r_state)
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
            end
            S_T1: begin
                // PC is loaded only on the first T1 cycle of a memory wait.
                Zlowout = 1'b1; Read = 1'b1; MDRin = 1'b1;
                PCin    = (r_wait == '0);
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            S_T3: begin
                Yin        = 1'b1;
                w_rout_en  = 1'b1;
                w_rout_idx = r_rb;
            end
            S_T4: begin
                Zin       = 1'b1;
                alu_op    = r_opcode;
                Cout      = w_is_imm;
                w_rout_en = !w_is_imm;
            end
            S_T5: begin
                Zlowout  = 1'b1;
                w_rin_en = w_is_alu;
                LOin     = w_is_md;
            end
            S_T6: begin
                Zhighout = c_MULDIV_EN;
                HIin     = c_MULDIV_EN;
            end
            default: ;
        endcase
    end

    assign busy      = (r_state != S_IDLE) && (r_state != S_HALT);
    assign halted    = r_halted;
    assign illegal   = r_illegal;
    assign mem_fault = r_fault;

    onehot_decoder #(.IDX_W(REG_IDX_W), .COUNT(REG_COUNT)) u_rout_dec (
        .i_idx    (w_rout_idx),
        .i_en     (w_rout_en),
        .o_onehot (Rout)
    );

    onehot_decoder #(.IDX_W(REG_IDX_W), .COUNT(REG_COUNT)) u_rin_dec (
        .i_idx    (r_ra),
        .i_en     (w_rin_en),
        .o_onehot (Rin)
    );

endmodule
`default_nettype wire
